// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect controls and fetched-instruction outputs.
interface fetch_unit_if;
  logic [11:0] imem_addr;
  logic [18:0] imem_data;
  logic        stall;
  logic        jump;
  logic        call;
  logic        ret;
  logic [11:0] target;
  logic [18:0] instr;
  logic        instr_valid;
  logic [11:0] instr_pc;
  logic [3:0]  depth;
  logic        stack_ovf;
  logic        stack_unf;

  // slave: the fetch unit itself; master: whoever drives memory data and redirects.
  modport slave (
    output imem_addr, instr, instr_valid, instr_pc, depth, stack_ovf, stack_unf,
    input  imem_data, stall, jump, call, ret, target
  );

  modport master (
    input  imem_addr, instr, instr_valid, instr_pc, depth, stack_ovf, stack_unf,
    output imem_data, stall, jump, call, ret, target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, jump/call/ret redirects with a return stack,
// one-cycle bubble on every taken redirect.
module fetch_unit #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.slave  bus
);

  localparam int          IW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [3:0]  FULL = 4'(STACK_DEPTH);

  logic [11:0] pc_q, pc_d;
  logic [18:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [11:0] ipc_q, ipc_d;
  logic [3:0]  depth_q, depth_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [11:0] stack_q [STACK_DEPTH];

  logic          push_en;
  logic          seq_fetch;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;

  assign push_idx = IW'(depth_q);
  assign top_idx  = IW'(depth_q - 4'd1);

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    ipc_d     = ipc_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push_en   = 1'b0;
    seq_fetch = 1'b0;
    if (!bus.stall) begin
      // ret wins over call, call over jump; a ret on an empty stack only flags and falls through.
      if (bus.ret && depth_q != 4'd0) begin
        pc_d    = stack_q[top_idx];
        depth_d = depth_q - 4'd1;
      end else if (bus.ret) begin
        unf_d     = 1'b1;
        seq_fetch = 1'b1;
      end else if (bus.call) begin
        if (depth_q != FULL) begin
          push_en = 1'b1;
          depth_d = depth_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
        pc_d = bus.target;
      end else if (bus.jump) begin
        pc_d = bus.target;
      end else begin
        seq_fetch = 1'b1;
      end

      if (seq_fetch) begin
        instr_d = bus.imem_data;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 12'd1;
      end else begin
        instr_d = 19'h0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 19'h0;
      valid_q <= 1'b0;
      ipc_q   <= 12'h000;
      depth_q <= 4'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ipc_q   <= ipc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return address is the word after the last issued instruction, not the current PC.
  always_ff @(posedge clk) begin
    if (rst && push_en) begin
      stack_q[push_idx] <= ipc_q + 12'd1;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.depth       = depth_q;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a queue-based model.
module tb_fetch_unit;

  localparam logic [11:0] RESET_PC    = 12'h000;
  localparam int          STACK_DEPTH = 8;

  logic clk;
  logic rst;
  fetch_unit_if bus ();

  logic [18:0] mem [4096];
  assign bus.imem_data = mem[bus.imem_addr];

  fetch_unit #(.RESET_PC(RESET_PC), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [11:0] m_pc;
  logic [18:0] m_instr;
  logic        m_valid;
  logic [11:0] m_ipc;
  logic        m_ovf;
  logic        m_unf;
  logic [11:0] m_stack [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("imem_addr",   32'(bus.imem_addr),   32'(m_pc));
    check("instr",       32'(bus.instr),       32'(m_instr));
    check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    check("instr_pc",    32'(bus.instr_pc),    32'(m_ipc));
    check("depth",       32'(bus.depth),       32'(m_stack.size()));
    check("stack_ovf",   32'(bus.stack_ovf),   32'(m_ovf));
    check("stack_unf",   32'(bus.stack_unf),   32'(m_unf));
  endtask

  // driver: one clock with the given inputs, model advanced, outputs checked after the edge
  task automatic step(input bit r, input bit s, input bit j, input bit c, input bit rt,
                      input logic [11:0] t);
    bit redirect;
    @(negedge clk);
    rst        = r;
    bus.stall  = s;
    bus.jump   = j;
    bus.call   = c;
    bus.ret    = rt;
    bus.target = t;
    redirect   = 1'b0;
    if (!r) begin
      m_pc    = RESET_PC;
      m_instr = 19'h0;
      m_valid = 1'b0;
      m_ipc   = 12'h000;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_stack.delete();
    end else if (!s) begin
      if (rt && m_stack.size() > 0) begin
        m_pc     = m_stack.pop_back();
        redirect = 1'b1;
      end else if (rt) begin
        m_unf = 1'b1;
      end else if (c) begin
        if (m_stack.size() < STACK_DEPTH) m_stack.push_back(m_ipc + 12'd1);
        else m_ovf = 1'b1;
        m_pc     = t;
        redirect = 1'b1;
      end else if (j) begin
        m_pc     = t;
        redirect = 1'b1;
      end
      if (redirect) begin
        m_instr = 19'h0;
        m_valid = 1'b0;
      end else begin
        m_instr = mem[m_pc];
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 12'd1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 12'h000);
  endtask

  initial begin
    rst = 1'b0; bus.stall = 1'b0; bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.target = 12'h000;
    for (int i = 0; i < 4096; i++) mem[i] = 19'(i);

    // reset, then free-running fetch from address 0
    step(0, 0, 0, 0, 0, 12'h000);
    step(0, 1, 1, 1, 1, 12'h123);
    run(4);
    check("free4_instr",  32'(bus.instr),     32'h3);
    check("free4_ipc",    32'(bus.instr_pc),  32'h3);
    check("free4_addr",   32'(bus.imem_addr), 32'h4);

    // PC wrap at the top of the address space
    step(1, 0, 1, 0, 0, 12'hFFE);
    run(3);
    check("wrap_ipc",  32'(bus.instr_pc),  32'h000);
    check("wrap_addr", 32'(bus.imem_addr), 32'h001);

    // stall holds everything, redirects ignored while stalled
    step(1, 0, 1, 0, 0, 12'h005);
    run(1);
    step(1, 1, 0, 0, 0, 12'h000);
    step(1, 1, 1, 0, 0, 12'h0AA);
    step(1, 1, 0, 1, 0, 12'h0BB);
    check("stall_ipc",   32'(bus.instr_pc), 32'h5);
    check("stall_depth", 32'(bus.depth),    32'h0);
    run(1);
    check("release_ipc", 32'(bus.instr_pc), 32'h6);

    // call from 10 to 40, later return to 11
    step(1, 0, 1, 0, 0, 12'd10);
    run(1);
    step(1, 0, 0, 1, 0, 12'd40);
    check("call_valid", 32'(bus.instr_valid), 32'h0);
    check("call_depth", 32'(bus.depth),       32'h1);
    run(3);
    check("callee_ipc", 32'(bus.instr_pc), 32'd42);
    step(1, 0, 0, 0, 1, 12'h000);
    run(1);
    check("ret_ipc",   32'(bus.instr_pc), 32'd11);
    check("ret_depth", 32'(bus.depth),    32'h0);

    // overflow on the ninth call, underflow on an empty ret
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0, 12'(100 + i * 4));
    check("ovf_depth", 32'(bus.depth),     32'h8);
    check("ovf_flag",  32'(bus.stack_ovf), 32'h1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1, 12'h000);
    step(1, 0, 0, 0, 1, 12'h000);
    check("unf_flag",  32'(bus.stack_unf),   32'h1);
    check("unf_valid", 32'(bus.instr_valid), 32'h1);
    run(2);
    check("ovf_sticky", 32'(bus.stack_ovf), 32'h1);

    // reset beats simultaneous redirects; without reset ret has top priority
    step(1, 0, 0, 1, 0, 12'h300);
    step(0, 0, 1, 1, 1, 12'h200);
    check("rst_over_depth", 32'(bus.depth),     32'h0);
    check("rst_over_addr",  32'(bus.imem_addr), 32'(RESET_PC));
    check("rst_over_ovf",   32'(bus.stack_ovf), 32'h0);
    run(1);
    step(1, 0, 0, 1, 0, 12'h300);
    step(1, 0, 1, 1, 1, 12'h200);
    check("prio_addr",  32'(bus.imem_addr),   32'h001);
    check("prio_depth", 32'(bus.depth),       32'h0);
    check("prio_valid", 32'(bus.instr_valid), 32'h0);

    // random traffic
    for (int i = 0; i < 4096; i++) mem[i] = 19'($urandom);
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0,
           12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
